// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and iterative-op selector for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_COMP = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [1:0] {IT_MUL, IT_DIVU, IT_REMU} iter_op_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift-add multiplier and restoring unsigned divider, one bit per cycle.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             start,
  input  iter_op_t         op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt;
  iter_op_t         op_q;
  logic [WIDTH-1:0] acc;   // product accumulator / partial remainder
  logic [WIDTH-1:0] sh;    // multiplier / dividend-becoming-quotient
  logic [WIDTH-1:0] dv;    // shifting multiplicand / fixed divisor
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  always_comb begin
    trial = {acc, sh[WIDTH-1]};
    diff  = trial - {1'b0, dv};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      op_q <= IT_MUL;
      acc  <= '0;
      sh   <= '0;
      dv   <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else if (start) begin
        busy <= 1'b1;
        cnt  <= '0;
        op_q <= op;
        acc  <= '0;
        sh   <= (op == IT_MUL) ? b : a;
        dv   <= (op == IT_MUL) ? a : b;
      end else if (busy) begin
        if (op_q == IT_MUL) begin
          if (sh[0]) acc <= acc + dv;
          dv <= dv << 1;
          sh <= sh >> 1;
        end else if (diff[WIDTH]) begin
          acc <= trial[WIDTH-1:0];
          sh  <= {sh[WIDTH-2:0], 1'b0};
        end else begin
          // A zero divisor never borrows, giving all-ones quotient and remainder = dividend.
          acc <= diff[WIDTH-1:0];
          sh  <= {sh[WIDTH-2:0], 1'b1};
        end
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign result = (op_q == IT_DIVU) ? sh : acc;

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle EX-stage ALU: operand mux, single-cycle datapath, FSM and result register.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alucontrol,
  input  logic             alusrc,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] inimm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             illegal
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  state_t           state, state_next;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, operand_b, res1;
  logic             illegal1, accept, iter_start, iter_busy, iter_done;
  logic [WIDTH-1:0] iter_result;
  iter_op_t         iter_op;

  assign in_ready   = (state == IDLE);
  assign accept     = in_valid & in_ready;
  assign operand_b  = alusrc ? inimm : in2;
  assign iter_start = accept & ~flush & is_iter_op(alucontrol);

  always_comb begin
    case (alucontrol)
      OP_DIVU: iter_op = IT_DIVU;
      OP_REMU: iter_op = IT_REMU;
      default: iter_op = IT_MUL;
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .abort  (flush),
    .start  (iter_start),
    .op     (iter_op),
    .a      (in1),
    .b      (operand_b),
    .busy   (iter_busy),
    .done   (iter_done),
    .result (iter_result)
  );

  always_comb begin
    res1     = '0;
    illegal1 = 1'b0;
    case (op_q)
      OP_AND:  res1 = a_q & b_q;
      OP_OR:   res1 = a_q | b_q;
      OP_ADD:  res1 = a_q + b_q;
      OP_XOR:  res1 = a_q ^ b_q;
      OP_SLL:  res1 = a_q << b_q[SH_W-1:0];
      OP_SRL:  res1 = a_q >> b_q[SH_W-1:0];
      OP_SUB:  res1 = a_q - b_q;
      OP_SRA:  res1 = WIDTH'($signed(a_q) >>> b_q[SH_W-1:0]);
      OP_COMP: res1 = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OP_SLTU: res1 = {{(WIDTH-1){1'b0}}, a_q < b_q};
      OP_MUL, OP_DIVU, OP_REMU: res1 = '0;
      default: illegal1 = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_next = is_iter_op(alucontrol) ? BUSY : DONE;
        BUSY: begin
          if (iter_done)      state_next = DONE;
          else if (!iter_busy) state_next = IDLE;
        end
        DONE: if (out_valid && out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Single-cycle results are registered one edge after entering DONE, matching the pipeline slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out       <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= alucontrol;
        a_q  <= in1;
        b_q  <= operand_b;
      end
      if (state == BUSY && iter_done) begin
        out       <= iter_result;
        zero      <= (iter_result == '0);
        illegal   <= 1'b0;
        out_valid <= 1'b1;
      end else if (state == DONE && !out_valid) begin
        out       <= res1;
        zero      <= (res1 == '0);
        illegal   <= illegal1;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed table-driven bench for alu_mc (WIDTH=32) plus flush/reset abort sequences.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, alusrc, out_valid, out_ready, zero, illegal;
  logic [3:0]  alucontrol;
  logic [31:0] in1, in2, inimm, out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        src;
    logic [31:0] a, b2, imm, exp;
    logic        ez, eil;
    int          lat, hold;
  } vec_t;

  vec_t vecs[$];

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .alusrc(alusrc), .in1(in1), .in2(in2), .inimm(inimm),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic src,
                              input logic [31:0] a, input logic [31:0] b2, input logic [31:0] imm,
                              input logic [31:0] exp, input logic ez, input logic eil,
                              input int lat, input int hold);
    vec_t v;
    v.name = name; v.op = op; v.src = src; v.a = a; v.b2 = b2; v.imm = imm;
    v.exp = exp; v.ez = ez; v.eil = eil; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input vec_t v);
    int cyc = 0;
    bit saw_ready = 0;
    wait_ready(v.name);
    in_valid = 1'b1; alucontrol = v.op; alusrc = v.src;
    in1 = v.a; in2 = v.b2; inimm = v.imm; out_ready = 1'b0;
    @(posedge clk); #1;
    // scramble inputs after acceptance; the result must not change
    in_valid = 1'b0; alucontrol = 4'($urandom); alusrc = ~v.src;
    in1 = $urandom; in2 = $urandom; inimm = $urandom;
    while (!out_valid && cyc < 100) begin
      if (in_ready) saw_ready = 1;
      @(posedge clk); #1; cyc++;
    end
    check({v.name, "_latency"}, 32'(cyc), 32'(v.lat));
    check({v.name, "_busy_ready_low"}, 32'(saw_ready), 32'd0);
    check({v.name, "_out"}, out, v.exp);
    check({v.name, "_zero"}, 32'(zero), 32'(v.ez));
    check({v.name, "_illegal"}, 32'(illegal), 32'(v.eil));
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      check({v.name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({v.name, "_hold_out"}, out, v.exp);
      check({v.name, "_hold_zero"}, 32'(zero), 32'(v.ez));
      check({v.name, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({v.name, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic no_valid_for(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alucontrol = '0; alusrc = 1'b0;
    in1 = '0; in2 = '0; inimm = '0; out_ready = 1'b0;

    vecs.push_back(mk("add_imm",  OP_ADD,  1, 32'd7,        32'h100,      32'hFFFF_FFFD, 32'd4,         0, 0, 1, 0));
    vecs.push_back(mk("sub_zero", OP_SUB,  0, 32'd5,        32'd5,        32'd99,        32'd0,         1, 0, 1, 0));
    vecs.push_back(mk("add_wrap", OP_ADD,  0, 32'hFFFF_FFFF, 32'd1,       32'd0,         32'd0,         1, 0, 1, 0));
    vecs.push_back(mk("comp",     OP_COMP, 0, 32'hFFFF_FFFF, 32'd1,       32'd0,         32'd1,         0, 0, 1, 0));
    vecs.push_back(mk("sltu",     OP_SLTU, 0, 32'hFFFF_FFFF, 32'd1,       32'd0,         32'd0,         1, 0, 1, 0));
    vecs.push_back(mk("sra",      OP_SRA,  1, 32'h8000_0000, 32'd0,       32'd4,         32'hF800_0000, 0, 0, 1, 0));
    vecs.push_back(mk("srl",      OP_SRL,  1, 32'h8000_0000, 32'd0,       32'd4,         32'h0800_0000, 0, 0, 1, 0));
    vecs.push_back(mk("sll_mask", OP_SLL,  1, 32'd1,        32'd0,        32'd33,        32'd2,         0, 0, 1, 0));
    vecs.push_back(mk("and",      OP_AND,  0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0,       32'h00F0_00F0, 0, 0, 1, 0));
    vecs.push_back(mk("or",       OP_OR,   0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0,       32'hFFF0_FFF0, 0, 0, 1, 0));
    vecs.push_back(mk("xor_hold", OP_XOR,  0, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0,       32'h5A5A_A5A5, 0, 0, 1, 5));
    vecs.push_back(mk("mul",      OP_MUL,  0, 32'h0001_0003, 32'd5,       32'd0,         32'h0005_000F, 0, 0, 33, 0));
    vecs.push_back(mk("mul_ones", OP_MUL,  1, 32'hFFFF_FFFF, 32'd0,       32'hFFFF_FFFF, 32'd1,         0, 0, 33, 0));
    vecs.push_back(mk("divu",     OP_DIVU, 0, 32'd100,      32'd7,        32'd0,         32'd14,        0, 0, 33, 0));
    vecs.push_back(mk("remu",     OP_REMU, 0, 32'd100,      32'd7,        32'd0,         32'd2,         0, 0, 33, 3));
    vecs.push_back(mk("divu_0",   OP_DIVU, 0, 32'd9,        32'd0,        32'd5,         32'hFFFF_FFFF, 0, 0, 33, 0));
    vecs.push_back(mk("remu_0",   OP_REMU, 0, 32'd9,        32'd0,        32'd5,         32'd9,         0, 0, 33, 0));
    vecs.push_back(mk("divu_sm",  OP_DIVU, 1, 32'd7,        32'd0,        32'd100,       32'd0,         1, 0, 33, 0));
    vecs.push_back(mk("ill_f",    4'b1111, 0, 32'h1234_5678, 32'h1,       32'd0,         32'd0,         1, 1, 1, 0));
    vecs.push_back(mk("ill_b",    4'b1011, 0, 32'hDEAD_BEEF, 32'h3,       32'd0,         32'd0,         1, 1, 1, 0));

    // reset state
    #12;
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_out",     out,            32'd0);
    check("rst_zero",    32'(zero),      32'd0);
    check("rst_illegal", 32'(illegal),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_op(vecs[i]);

    // flush at iteration 10 of a DIVU
    in_valid = 1'b1; alucontrol = OP_DIVU; alusrc = 1'b0; in1 = 32'd1000; in2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_valid",    32'(out_valid), 32'd0);
    no_valid_for("flush_no_result", 40);

    // flush wins over a same-cycle accept
    in_valid = 1'b1; alucontrol = OP_ADD; in1 = 32'd3; in2 = 32'd4; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_prio_ready", 32'(in_ready), 32'd1);
    no_valid_for("flush_prio_no_result", 3);

    // asynchronous reset in the middle of a MUL
    in_valid = 1'b1; alucontrol = OP_MUL; alusrc = 1'b0; in1 = 32'd12; in2 = 32'd12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid",    32'(out_valid), 32'd0);
    check("midrst_out",      out,            32'd0);
    check("midrst_in_ready", 32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    no_valid_for("midrst_no_result", 40);

    run_op(mk("add_after", OP_ADD, 0, 32'd1, 32'd1, 32'd77, 32'd2, 0, 0, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
